// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions: response codes, bridge state encoding and a
// helper that classifies a response code as an error.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    // EXOKAY is meaningless without exclusive access, so only OKAY is success.
    function automatic logic resp_is_err(input logic [1:0] code);
        return code != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, clears on request,
// saturates at TIMEOUT_CYC-1 and raises a sticky flag when it gets there.
module axi_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic timeout_flag
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             flag_reg;

    // Next count: clear wins, otherwise count up while enabled and not saturated.
    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (enable && (cnt_reg != LIMIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Counter and sticky flag; the flag sets on the edge the count reaches the limit.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_reg  <= '0;
            flag_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (enable && !clear && (cnt_next == LIMIT)) begin
                flag_reg <= 1'b1;
            end
        end
    end

    assign timeout_flag = flag_reg;

endmodule

// File: rtl/axi_lite_master.sv
// CPU-request to AXI-lite bridge with a single outstanding transaction.
// Channel valid/ready outputs are decoded from the registered state, so
// they behave exactly like registered outputs.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                timeout_flag,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_t              state_reg;
    state_t              state_next;
    logic                aw_done_reg;
    logic                w_done_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;
    logic [DATA_W-1:0]   resp_rdata_reg;
    logic                resp_err_reg;

    logic req_accept;
    logic aw_hs;
    logic w_hs;
    logic r_hs;
    logic b_hs;
    logic wait_state;

    assign req_accept = req_valid && req_ready;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign r_hs       = rvalid && rready;
    assign b_hs       = bvalid && bready;
    assign wait_state = (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                        (state_reg == WR_REQ)  || (state_reg == WR_RESP);

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a write leaves WR_REQ once both AW and W have completed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = req_we ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready)   state_next = RD_DATA;
            RD_DATA: if (rvalid)    state_next = RESP;
            WR_REQ:  if ((aw_done_reg || awready) && (w_done_reg || wready))
                         state_next = WR_RESP;
            WR_RESP: if (bvalid)    state_next = RESP;
            RESP:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output decode from the current state and the per-channel done bits.
    always_comb begin
        req_ready  = (state_reg == IDLE);
        arvalid    = (state_reg == RD_ADDR);
        rready     = (state_reg == RD_DATA);
        awvalid    = (state_reg == WR_REQ) && !aw_done_reg;
        wvalid     = (state_reg == WR_REQ) && !w_done_reg;
        bready     = (state_reg == WR_RESP);
        resp_valid = (state_reg == RESP);
        araddr     = addr_reg;
        awaddr     = addr_reg;
        wdata      = wdata_reg;
        wstrb      = wstrb_reg;
        resp_rdata = resp_rdata_reg;
        resp_err   = resp_err_reg;
    end

    // Request capture, AW/W completion tracking and response capture.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            if (req_accept) begin
                addr_reg    <= req_addr;
                wdata_reg   <= req_wdata;
                wstrb_reg   <= req_wstrb;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;
            if (r_hs) begin
                resp_rdata_reg <= rdata;
                resp_err_reg   <= resp_is_err(rresp);
            end
            if (b_hs) begin
                resp_err_reg <= resp_is_err(bresp);
            end
        end
    end

    // The watchdog only observes; a hung responder is flagged, never abandoned.
    axi_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .clear        (state_next != state_reg),
        .enable       (wait_state),
        .timeout_flag (timeout_flag)
    );

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_axi_lite_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int TO_CYC = 16;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                timeout_flag;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_lite_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .timeout_flag (timeout_flag),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    task automatic responder_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Issue one request from an idle bridge and wait (bounded) for resp_valid.
    // lat is the cycle count after the accept edge, -1 if no response came.
    task automatic do_request(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input logic [7:0] ws,
                              output int lat, output logic [DATA_W-1:0] rd,
                              output logic err);
        lat = -1; rd = '0; err = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(posedge aclk); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge aclk);
            if (resp_valid === 1'b1) begin
                lat = i; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        @(posedge aclk); #1;
        $display("txn we=%0b addr=%h lat=%0d rdata=%h err=%0b", we, addr, lat, rd, err);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0;
        responder_idle();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            errors++; $display("FAIL reset_channels got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        checks++;
        if ({resp_valid, resp_err, timeout_flag} !== 3'b0) begin
            errors++; $display("FAIL reset_resp got=%b exp=000", {resp_valid, resp_err, timeout_flag});
        end
        checks++;
        if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        $display("txn reset");
    endtask

    // Zero-wait read: arvalid at N+1, rready at N+2, resp_valid at N+3.
    task automatic test_read_zero_wait();
        arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; rdata = 64'h1122334455667788;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1000;
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready got=%b exp=1", req_ready); end
        @(posedge aclk); #1;
        req_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({arvalid, rready, req_ready} !== 3'b100) begin
            errors++; $display("FAIL rd_cyc1 arvalid,rready,req_ready got=%b exp=100", {arvalid, rready, req_ready});
        end
        checks++;
        if (araddr !== 32'h0000_1000) begin errors++; $display("FAIL rd_araddr got=%h exp=00001000", araddr); end
        @(negedge aclk);
        checks++;
        if ({arvalid, rready, resp_valid} !== 3'b010) begin
            errors++; $display("FAIL rd_cyc2 arvalid,rready,resp_valid got=%b exp=010", {arvalid, rready, resp_valid});
        end
        @(negedge aclk);
        checks++;
        if ({resp_valid, rready} !== 2'b10) begin
            errors++; $display("FAIL rd_cyc3 resp_valid,rready got=%b exp=10", {resp_valid, rready});
        end
        checks++;
        if (resp_rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_rdata got=%h exp=1122334455667788", resp_rdata);
        end
        checks++;
        if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", resp_err); end
        @(negedge aclk);
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_cyc4 resp_valid,req_ready got=%b exp=01", {resp_valid, req_ready});
        end
        @(posedge aclk); #1;
        responder_idle();
        $display("txn read addr=00001000 rdata=%h", resp_rdata);
    endtask

    // Write with AW stalled three cycles and W accepted immediately.
    task automatic test_write_stall();
        logic exp_w;
        responder_idle();
        arready = 1'b1; wready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_2008;
        req_wdata = 64'hDEADBEEF00000001; req_wstrb = 8'h0F;
        @(posedge aclk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) awready = 1'b1;
            exp_w = (c == 1);
            @(negedge aclk);
            checks++;
            if ({awvalid, wvalid, bready} !== {1'b1, exp_w, 1'b0}) begin
                errors++; $display("FAIL wr_stall_c%0d awvalid,wvalid,bready got=%b exp=%b",
                                   c, {awvalid, wvalid, bready}, {1'b1, exp_w, 1'b0});
            end
            checks++;
            if (awaddr !== 32'h0000_2008) begin errors++; $display("FAIL wr_awaddr_c%0d got=%h exp=00002008", c, awaddr); end
            if (c == 1) begin
                checks++;
                if ({wdata, wstrb} !== {64'hDEADBEEF00000001, 8'h0F}) begin
                    errors++; $display("FAIL wr_wdata got=%h/%h exp=deadbeef00000001/0f", wdata, wstrb);
                end
            end
            @(posedge aclk); #1;
        end
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, bready, resp_valid} !== 4'b0010) begin
            errors++; $display("FAIL wr_bphase awvalid,wvalid,bready,resp_valid got=%b exp=0010",
                               {awvalid, wvalid, bready, resp_valid});
        end
        @(posedge aclk); #1;
        bvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({resp_valid, resp_err, bready} !== 3'b100) begin
            errors++; $display("FAIL wr_resp resp_valid,resp_err,bready got=%b exp=100", {resp_valid, resp_err, bready});
        end
        checks++;
        if (resp_rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_rdata_hold got=%h exp=1122334455667788", resp_rdata);
        end
        @(posedge aclk); #1;
        responder_idle();
        $display("txn write addr=00002008 wdata=deadbeef00000001 wstrb=0f err=%0b", resp_err);
    endtask

    // Non-OKAY responses on both paths, and OKAY clearing the error again.
    task automatic test_errors();
        int lat;
        logic [DATA_W-1:0] rd;
        logic err;
        responder_idle();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        do_request(1'b1, 32'h0000_2010, 64'h5, 8'hFF, lat, rd, err);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL err_wr_lat got=%0d exp=3", lat); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_wr_slverr got=%b exp=1", err); end

        bresp = 2'b01;
        do_request(1'b1, 32'h0000_2018, 64'h6, 8'h01, lat, rd, err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_wr_exokay got=%b exp=1", err); end

        responder_idle();
        arready = 1'b1; rvalid = 1'b1; rresp = 2'b11; rdata = 64'hCAFEF00D12345678;
        do_request(1'b0, 32'h0000_3000, 64'h0, 8'h00, lat, rd, err);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL err_rd_lat got=%0d exp=3", lat); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_rd_decerr got=%b exp=1", err); end
        checks++;
        if (rd !== 64'hCAFEF00D12345678) begin errors++; $display("FAIL err_rd_rdata got=%h exp=cafef00d12345678", rd); end

        rresp = 2'b00; rdata = 64'h0F0F0F0F0F0F0F0F;
        do_request(1'b0, 32'h0000_3008, 64'h0, 8'h00, lat, rd, err);
        checks++;
        if ({err, rd} !== {1'b0, 64'h0F0F0F0F0F0F0F0F}) begin
            errors++; $display("FAIL err_rd_okay got=%b/%h exp=0/0f0f0f0f0f0f0f0f", err, rd);
        end
        responder_idle();
    endtask

    // req_valid held high: read then write, second accept right after resp_valid.
    task automatic test_back_to_back();
        responder_idle();
        arready = 1'b1; rvalid = 1'b1; rdata = 64'h0102030405060708;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000;
        @(posedge aclk); #1;
        req_we = 1'b1; req_addr = 32'h0000_4008; req_wdata = 64'hA5A5A5A5A5A5A5A5; req_wstrb = 8'hF0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_c%0d req_ready got=%b exp=0", c, req_ready); end
        end
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_resp got=%b exp=1", resp_valid); end
        $display("txn b2b read addr=00004000 rdata=%h", resp_rdata);
        @(negedge aclk);
        checks++;
        if ({req_ready, resp_valid, awvalid} !== 3'b100) begin
            errors++; $display("FAIL b2b_gap req_ready,resp_valid,awvalid got=%b exp=100", {req_ready, resp_valid, awvalid});
        end
        @(posedge aclk); #1;
        req_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, awaddr} !== {2'b11, 32'h0000_4008}) begin
            errors++; $display("FAIL b2b_wr_addr awvalid,wvalid,awaddr got=%b%b/%h exp=11/00004008", awvalid, wvalid, awaddr);
        end
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b1, 64'h0102030405060708}) begin
            errors++; $display("FAIL b2b_wr_resp got=%b/%h exp=1/0102030405060708", resp_valid, resp_rdata);
        end
        $display("txn b2b write addr=00004008 err=%0b", resp_err);
        @(posedge aclk); #1;
        responder_idle();
    endtask

    // AR held off past the watchdog limit; flag rises at wait-cycle TO_CYC-1.
    task automatic test_timeout();
        int lat;
        responder_idle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000;
        @(posedge aclk); #1;
        req_valid = 1'b0;
        for (int j = 0; j < TO_CYC + 5; j++) begin
            @(negedge aclk);
            if (arvalid !== 1'b1 || araddr !== 32'h0000_5000) begin
                checks++; errors++;
                $display("FAIL to_arvalid_w%0d got=%b/%h exp=1/00005000", j, arvalid, araddr);
            end
            if (j == TO_CYC - 2) begin
                checks++;
                if (timeout_flag !== 1'b0) begin errors++; $display("FAIL to_early w%0d got=%b exp=0", j, timeout_flag); end
            end
            if (j == TO_CYC - 1) begin
                checks++;
                if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_set w%0d got=%b exp=1", j, timeout_flag); end
            end
            @(posedge aclk); #1;
        end
        checks++;
        arready = 1'b1; rvalid = 1'b1; rdata = 64'h00000000DEADC0DE;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge aclk);
            if (resp_valid === 1'b1) begin lat = i; break; end
        end
        if (lat !== 3 || resp_rdata !== 64'h00000000DEADC0DE || timeout_flag !== 1'b1) begin
            errors++; $display("FAIL to_complete lat=%0d rdata=%h flag=%b exp=3/00000000deadc0de/1",
                               lat, resp_rdata, timeout_flag);
        end
        $display("txn read addr=00005000 after stall rdata=%h timeout=%0b", resp_rdata, timeout_flag);
        @(posedge aclk); #1;
        responder_idle();
    endtask

    // Reset asserted while waiting in RD_DATA aborts the read silently.
    task automatic test_reset_mid();
        int pulses;
        responder_idle();
        arready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000;
        @(posedge aclk); #1;
        req_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL rst_mid_rdata_state rready got=%b exp=1", rready); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++;
        if ({rready, req_ready, resp_valid, timeout_flag} !== 4'b0100) begin
            errors++; $display("FAIL rst_mid rready,req_ready,resp_valid,timeout got=%b exp=0100",
                               {rready, req_ready, resp_valid, timeout_flag});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        rvalid = 1'b1; rdata = 64'hFFFF;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (resp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_resp pulses got=%0d exp=0", pulses); end
        $display("txn read addr=00006000 aborted by reset");
        @(posedge aclk); #1;
        responder_idle();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_stall();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Initiator-side bridge that turns a simple CPU memory request (IFU/LSU) into one AXI-lite transaction toward the memory responder (sim SRAM or crossbar port).
- One outstanding transaction at a time: read uses AR then R; write uses AW plus W, then B.
- Returns read data and an error flag to the core as a one-cycle response pulse.
- Includes a watchdog that flags a hung responder for debug without violating AXI rules.

Parameters:
ADDR_W, 32, address width on CPU and AXI sides
DATA_W, 64, data width; strobe width is DATA_W/8
TIMEOUT_CYC, 1024, wait-state cycles before timeout_flag sets

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  bridge can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  write byte strobes
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  read data (valid with resp_valid on reads)
resp_err  out  1  rresp/bresp was not OKAY
timeout_flag  out  1  sticky; a wait state exceeded TIMEOUT_CYC
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AR channel
rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  R channel
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AW channel
wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel
bresp/bvalid/bready  in/in/out  2/1/1  B channel

Behaviour:
- Reset: aresetn sampled at posedge aclk, synchronous, active-low.
  - Reset values: state IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err, timeout_flag = 0; resp_rdata = 0.
  - Reset mid-transaction aborts it; all outputs take reset values on the next edge.
- req_ready = (state==IDLE), combinational. A request is accepted on req_valid & req_ready; addr, wdata and wstrb are latched at that edge.
- IDLE:
  - read accepted -> RD_ADDR, arvalid=1 next cycle.
  - write accepted -> WR_REQ, awvalid=1 and wvalid=1 next cycle.
- RD_ADDR: araddr held stable with arvalid high until arready. On the handshake: arvalid<=0, rready<=1, go to RD_DATA.
- RD_DATA: on rvalid & rready: resp_rdata<=rdata, resp_err<=(rresp!=2'b00), rready<=0, go to RESP.
- WR_REQ:
  - AW and W complete independently; each valid drops on its own handshake, and internal aw_done/w_done bits record completion.
  - When both are done (same cycle or different cycles): bready<=1, go to WR_RESP.
  - Neither valid is ever withdrawn before its handshake.
- WR_RESP: on bvalid & bready: resp_err<=(bresp!=2'b00), bready<=0, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - On writes, resp_rdata holds its previous value.
  - No back-pressure on the response; the CPU must sample it.
- Latency with a zero-wait responder:
  - accept at edge N; arvalid or awvalid/wvalid high in cycle N+1.
  - read: rready at N+2, resp_valid at N+3.
  - write: bready at N+2, resp_valid at N+3.
- Watchdog:
  - Counter clears on every state change and counts each cycle spent in RD_ADDR, RD_DATA, WR_REQ or WR_RESP.
  - When it reaches TIMEOUT_CYC-1, timeout_flag<=1 (sticky until reset).
  - The counter saturates. The transaction is not aborted.
- AXI outputs: araddr/awaddr = latched addr unmodified; the responder supplies the upper address bits. wdata/wstrb = latched values.
- Unused response codes: EXOKAY and DECERR both count as errors.

Decomposition:
- Package axi_pkg:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state enum IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- One sub-module, axi_watchdog: counter with clear, enable and saturation, plus the sticky flag output; parameter TIMEOUT_CYC.

Test Plan:
- Read, zero-wait responder, addr 0x0000_1000 holding 0x1122_3344_5566_7788 -> resp_valid at accept+3, resp_rdata=0x1122334455667788, resp_err=0.
- Write addr 0x0000_2008, wdata 0xDEAD_BEEF_0000_0001, wstrb 0x0F:
  - arready held 1, awready stalled 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles with awaddr stable, bready only after both handshakes, resp_err=0.
- Write with bresp=2'b10 -> resp_err=1; read with rresp=2'b11 -> resp_err=1, resp_rdata=rdata.
- req_valid held high for back-to-back read then write -> second request accepted only in the cycle after resp_valid; req_ready=0 throughout the first transaction.
- arready held 0 for TIMEOUT_CYC+5 cycles -> timeout_flag=1 at wait-cycle TIMEOUT_CYC-1; arvalid stays 1; after arready rises the read completes normally.
- aresetn low in the RD_DATA state -> next edge: rready=0, req_ready=1, resp_valid never pulses for the aborted read.
